// File: rtl/flag_cond_unit_if.sv
// rtl/flag_cond_unit_if.sv - ALU flag / condition-evaluation interface
interface flag_cond_unit_if;
  logic       flagWrite;
  logic       C;
  logic       L;
  logic       F;
  logic       Z;
  logic       N;
  logic       condReq;
  logic [3:0] cond;
  logic       saveFlags;
  logic       restoreFlags;
  logic       condTrue;
  logic       condValid;
  logic [4:0] psr;

  modport master (
    output flagWrite, C, L, F, Z, N, condReq, cond, saveFlags, restoreFlags,
    input  condTrue, condValid, psr
  );

  modport slave (
    input  flagWrite, C, L, F, Z, N, condReq, cond, saveFlags, restoreFlags,
    output condTrue, condValid, psr
  );
endinterface

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - PSR latch with shadow copy and branch condition evaluator
module flag_cond_unit #(
  parameter bit BYPASS = 1'b1
) (
  input logic              clk,
  input logic              reset,
  flag_cond_unit_if.slave  bus
);
  typedef enum logic {IDLE, EVAL} state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] psr_q;
  logic [4:0] shadow_q;
  logic [4:0] in_flags;
  logic [4:0] src;
  logic       cond_true_q;
  logic       eval;
  logic       cond_valid;

  assign in_flags = {bus.C, bus.L, bus.F, bus.Z, bus.N};

  // Restore beats a same-cycle flag write; save always captures the pre-edge PSR, so save+restore swaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr_q    <= 5'b0;
      shadow_q <= 5'b0;
    end else begin
      if (bus.restoreFlags)
        psr_q <= shadow_q;
      else if (bus.flagWrite)
        psr_q <= in_flags;
      if (bus.saveFlags)
        shadow_q <= psr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cond_true_q <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.condReq)
        cond_true_q <= eval;
    end
  end

  // Only a flag write bypasses; a restore is evaluated against the stored PSR.
  always_comb begin
    src  = (BYPASS && bus.flagWrite) ? in_flags : psr_q;
    eval = 1'b0;
    case (bus.cond)
      4'b0000: eval =  src[1];
      4'b0001: eval = ~src[1];
      4'b0010: eval =  src[4];
      4'b0011: eval = ~src[4];
      4'b0100: eval =  src[3];
      4'b0101: eval = ~src[3];
      4'b0110: eval =  src[0];
      4'b0111: eval = ~src[0];
      4'b1000: eval =  src[2];
      4'b1001: eval = ~src[2];
      4'b1010: eval = ~src[3] & ~src[1];
      4'b1011: eval =  src[3] |  src[1];
      4'b1100: eval = ~src[0] & ~src[1];
      4'b1101: eval =  src[0] |  src[1];
      4'b1110: eval = 1'b1;
      default: eval = 1'b0;
    endcase
  end

  // A reset arriving while in EVAL suppresses the pending pulse.
  always_comb begin
    state_next = IDLE;
    cond_valid = 1'b0;
    case (state)
      IDLE: if (bus.condReq) state_next = EVAL;
      EVAL: begin
        cond_valid = ~reset;
        if (bus.condReq) state_next = EVAL;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.condTrue  = cond_true_q;
  assign bus.condValid = cond_valid;
  assign bus.psr       = psr_q;
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - scoreboard bench for flag_cond_unit, BYPASS=1 and BYPASS=0 side by side
module tb_flag_cond_unit;
  logic       clk;
  logic       reset;
  logic       fw_d, cr_d, sv_d, rs_d;
  logic [4:0] fl_d;
  logic [3:0] cd_d;

  flag_cond_unit_if bus1 ();
  flag_cond_unit_if bus0 ();

  assign {bus1.flagWrite, bus0.flagWrite} = {2{fw_d}};
  assign {bus1.C, bus1.L, bus1.F, bus1.Z, bus1.N} = fl_d;
  assign {bus0.C, bus0.L, bus0.F, bus0.Z, bus0.N} = fl_d;
  assign {bus1.condReq, bus0.condReq} = {2{cr_d}};
  assign bus1.cond = cd_d;
  assign bus0.cond = cd_d;
  assign {bus1.saveFlags, bus0.saveFlags} = {2{sv_d}};
  assign {bus1.restoreFlags, bus0.restoreFlags} = {2{rs_d}};

  flag_cond_unit #(.BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  flag_cond_unit #(.BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  checking = 0;
  bit  q1[$];
  bit  q0[$];
  bit  hold1 = 0, hold0 = 0;
  bit [4:0] psr_m = 0, sh_m = 0;

  // Odd codes are the complement of the even code below them.
  function automatic bit ref_cond(input logic [3:0] cd, input bit [4:0] f);
    bit c, l, fv, z, n, base;
    {c, l, fv, z, n} = f;
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = fv;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return base ^ cd[0];
  endfunction

  task automatic step(input bit r, input bit fw, input bit [4:0] fl, input bit cr,
                      input logic [3:0] cd, input bit sv, input bit rs);
    bit [4:0] old;
    reset = r; fw_d = fw; fl_d = fl; cr_d = cr; cd_d = cd; sv_d = sv; rs_d = rs;
    if (r) begin
      q1.delete();
      q0.delete();
    end
    @(posedge clk);
    if (r) begin
      psr_m = 0; sh_m = 0; hold1 = 0; hold0 = 0;
    end else begin
      old = psr_m;
      if (cr) begin
        hold1 = ref_cond(cd, fw ? fl : old);
        hold0 = ref_cond(cd, old);
        q1.push_back(hold1);
        q0.push_back(hold0);
      end
      if (rs) psr_m = sh_m;
      else if (fw) psr_m = fl;
      if (sv) sh_m = old;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit e;
      n_cmp++;
      if (bus1.psr !== psr_m) begin
        n_err++; $display("FAIL psr_b1 got %b want %b t=%0t", bus1.psr, psr_m, $time);
      end
      n_cmp++;
      if (bus0.psr !== psr_m) begin
        n_err++; $display("FAIL psr_b0 got %b want %b t=%0t", bus0.psr, psr_m, $time);
      end
      n_cmp++;
      if (bus1.condValid === 1'b1) begin
        if (q1.size() == 0) begin
          n_err++; $display("FAIL valid_b1 got 1 want 0 t=%0t", $time);
        end else begin
          e = q1.pop_front();
          if (bus1.condTrue !== e) begin
            n_err++; $display("FAIL cond_b1 got %b want %b t=%0t", bus1.condTrue, e, $time);
          end
        end
      end else if (bus1.condValid !== 1'b0 || bus1.condTrue !== hold1) begin
        n_err++; $display("FAIL hold_b1 got v=%b t=%b want v=0 t=%b t=%0t",
                          bus1.condValid, bus1.condTrue, hold1, $time);
      end
      n_cmp++;
      if (bus0.condValid === 1'b1) begin
        if (q0.size() == 0) begin
          n_err++; $display("FAIL valid_b0 got 1 want 0 t=%0t", $time);
        end else begin
          e = q0.pop_front();
          if (bus0.condTrue !== e) begin
            n_err++; $display("FAIL cond_b0 got %b want %b t=%0t", bus0.condTrue, e, $time);
          end
        end
      end else if (bus0.condValid !== 1'b0 || bus0.condTrue !== hold0) begin
        n_err++; $display("FAIL hold_b0 got v=%b t=%b want v=0 t=%b t=%0t",
                          bus0.condValid, bus0.condTrue, hold0, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0;
    step(1, 1, 5'h1f, 0, 4'd0, 0, 0);
    checking = 1;
    step(1, 1, 5'h1f, 0, 4'd0, 0, 0);
    // write Z, then EQ and NE against it
    step(0, 1, 5'b00010, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 1, 4'b0000, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 1, 4'b0001, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    // same-cycle write and CS request
    step(1, 0, 5'b0, 0, 4'd0, 0, 0);
    step(0, 1, 5'b10000, 1, 4'b0010, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    for (int cd = 0; cd < 16; cd++)
      for (int fl = 0; fl < 32; fl++)
        step(0, 1, 5'(fl), 1, 4'(cd), 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    // shadow save / restore / override / swap
    step(0, 1, 5'b10000, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 1, 0);
    step(0, 1, 5'b00010, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 1, 4'b0000, 0, 1);
    step(0, 1, 5'b01000, 1, 4'b0100, 0, 1);
    step(0, 1, 5'b00101, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 1, 1);
    step(0, 0, 5'b0, 0, 4'bx, 1, 1);
    // request then reset in the EVAL cycle
    step(0, 1, 5'b11111, 1, 4'b1110, 0, 0);
    step(1, 0, 5'b0, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 5'b0, 1, 4'(4'b1110 - i), 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit cr;
      cr = 1'($urandom);
      step(($urandom % 60) == 0, 1'($urandom), 5'($urandom), cr,
           cr ? 4'($urandom) : 4'bx, ($urandom % 5) == 0, ($urandom % 5) == 0);
    end
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    step(0, 0, 5'b0, 0, 4'bx, 0, 0);
    n_cmp++;
    if (q1.size() != 0 || q0.size() != 0) begin
      n_err++;
      $display("FAIL missing_valid got pending %0d/%0d want 0/0", q1.size(), q0.size());
    end
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
